// File: rtl/inst_mem_pipe_if.sv
// Fetch and debug port bundle of the pipelined instruction memory.
// master = CPU / harness side, slave = the memory.
interface inst_mem_pipe_if;
    logic        fetch_req;
    logic [29:0] fetch_addr;
    logic        fetch_hold;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        fetch_fault;
    logic [29:0] debug_addr;
    logic        debug_wr_en;
    logic [31:0] debug_wdata;
    logic [31:0] debug_rdata;
    logic [31:0] fetch_count;

    modport master (
        output fetch_req, fetch_addr, fetch_hold,
        output debug_addr, debug_wr_en, debug_wdata,
        input  fetch_ready, fetch_valid, fetch_data, fetch_fault,
        input  debug_rdata, fetch_count
    );

    modport slave (
        input  fetch_req, fetch_addr, fetch_hold,
        input  debug_addr, debug_wr_en, debug_wdata,
        output fetch_ready, fetch_valid, fetch_data, fetch_fault,
        output debug_rdata, fetch_count
    );
endinterface

// File: rtl/inst_mem_pipe.sv
// Word-addressed instruction memory with a LATENCY-deep valid-tagged read pipeline,
// CPU hold, out-of-range fault, saturating fetch counter and an independent debug port.
module inst_mem_pipe #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned LATENCY    = 1
) (
    input  logic           clk,
    input  logic           rst,
    inst_mem_pipe_if.slave bus
);
    localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
    localparam int unsigned LAST   = LATENCY - 1;
    localparam int unsigned OFF_HI = ADDR_WIDTH + 2;

    typedef struct packed {
        logic        valid;
        logic        fault;
        logic [31:0] data;
    } stage_t;

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("inst_mem_pipe: LATENCY must be within 1..4");
    end
    if (BASE_ADDR[OFF_HI-1:0] != '0) begin : g_bad_base
        $error("inst_mem_pipe: BASE_ADDR must be aligned to the memory size");
    end

    logic [31:0]           r_mem [DEPTH];
    stage_t                r_stage [LATENCY];
    logic [31:0]           r_debug_rdata;
    logic [31:0]           r_fetch_count;

    logic [29:0]           w_f_off;
    logic [29:0]           w_d_off;
    logic                  w_f_in;
    logic                  w_d_in;
    logic [ADDR_WIDTH-1:0] w_f_idx;
    logic [ADDR_WIDTH-1:0] w_d_idx;
    stage_t                w_stage_in;

    // Word offsets from the base; BASE_ADDR is aligned, so its low byte bits never matter.
    assign w_f_off = bus.fetch_addr - BASE_ADDR[31:2];
    assign w_d_off = bus.debug_addr - BASE_ADDR[31:2];
    assign w_f_in  = (w_f_off >> ADDR_WIDTH) == 30'd0;
    assign w_d_in  = (w_d_off >> ADDR_WIDTH) == 30'd0;
    assign w_f_idx = w_f_off[ADDR_WIDTH-1:0];
    assign w_d_idx = w_d_off[ADDR_WIDTH-1:0];

    always_comb begin
        w_stage_in = '0;
        if (bus.fetch_req) begin
            w_stage_in.valid = 1'b1;
            w_stage_in.fault = !w_f_in;
            w_stage_in.data  = w_f_in ? r_mem[w_f_idx] : 32'd0;
        end
    end

    // Fetch pipeline and counter; hold freezes everything here.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                r_stage[i] <= '0;
            end
            r_fetch_count <= '0;
        end else if (!bus.fetch_hold) begin
            r_stage[0] <= w_stage_in;
            for (int i = 1; i < int'(LATENCY); i++) begin
                r_stage[i] <= r_stage[i-1];
            end
            if (bus.fetch_req && w_f_in && (r_fetch_count != '1)) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    // Storage is never reset; non-blocking write gives read-before-write on collisions.
    always_ff @(posedge clk) begin
        if (bus.debug_wr_en && w_d_in) begin
            r_mem[w_d_idx] <= bus.debug_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_debug_rdata <= '0;
        end else begin
            r_debug_rdata <= w_d_in ? r_mem[w_d_idx] : 32'd0;
        end
    end

    assign bus.fetch_ready = !bus.fetch_hold;
    assign bus.fetch_valid = r_stage[LAST].valid;
    assign bus.fetch_fault = r_stage[LAST].fault;
    assign bus.fetch_data  = r_stage[LAST].data;
    assign bus.debug_rdata = r_debug_rdata;
    assign bus.fetch_count = r_fetch_count;
endmodule

// File: tb/tb_inst_mem_pipe.sv
// Bench for inst_mem_pipe: three instances (LATENCY 1/3/4, two bases) share one stimulus
// stream and are checked every cycle against a queue-based reference model.
module tb_inst_mem_pipe;
    localparam int          N     = 3;
    localparam int unsigned AW    = 12;
    localparam int unsigned DEPTH = 4096;

    function automatic int unsigned lat_of(int k);
        case (k)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] base_of(int k);
        return (k == 1) ? 32'h0000_4000 : 32'h0000_0000;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req;
    logic [29:0] addr;
    logic        hold;
    logic [29:0] dbg_addr;
    logic        dbg_we;
    logic [31:0] dbg_wdata;

    logic        o_ready [N];
    logic        o_valid [N];
    logic        o_fault [N];
    logic [31:0] o_data  [N];
    logic [31:0] o_rdata [N];
    logic [31:0] o_count [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        inst_mem_pipe_if u_if ();
        inst_mem_pipe #(
            .ADDR_WIDTH (AW),
            .BASE_ADDR  (base_of(g)),
            .LATENCY    (lat_of(g))
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (u_if.slave)
        );
        assign u_if.fetch_req   = req;
        assign u_if.fetch_addr  = addr;
        assign u_if.fetch_hold  = hold;
        assign u_if.debug_addr  = dbg_addr;
        assign u_if.debug_wr_en = dbg_we;
        assign u_if.debug_wdata = dbg_wdata;
        assign o_ready[g] = u_if.fetch_ready;
        assign o_valid[g] = u_if.fetch_valid;
        assign o_fault[g] = u_if.fetch_fault;
        assign o_data[g]  = u_if.fetch_data;
        assign o_rdata[g] = u_if.debug_rdata;
        assign o_count[g] = u_if.fetch_count;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: each accepted fetch is queued with the unheld-cycle number it is due on.
    typedef struct {
        logic        fault;
        logic [31:0] data;
        bit          known;
        int unsigned due;
    } ent_t;

    logic [31:0] m_mem   [N][DEPTH];
    bit          m_known [N][DEPTH];
    ent_t        m_q     [N][$];
    int unsigned m_tick  [N];
    logic        m_valid [N];
    logic        m_fault [N];
    logic [31:0] m_data  [N];
    bit          m_dknown[N];
    bit          m_post_rst[N];
    logic [31:0] m_rdata [N];
    bit          m_rknown[N];
    logic [31:0] m_cnt   [N];

    function automatic bit in_rng(int k, logic [29:0] wa, output int unsigned idx);
        logic [31:0] off;
        bit          ok;
        off = {wa, 2'b00} - base_of(k);
        ok  = off < 32'(4 * DEPTH);
        idx = ok ? int'(off / 4) : 0;
        return ok;
    endfunction

    task automatic model_step(input int k);
        int unsigned fidx;
        int unsigned didx;
        bit          fin;
        bit          din;
        ent_t        e;
        fin = in_rng(k, addr, fidx);
        din = in_rng(k, dbg_addr, didx);
        if (rst) begin
            m_q[k].delete();
            m_valid[k]    = 1'b0;
            m_fault[k]    = 1'b0;
            m_data[k]     = 32'd0;
            m_dknown[k]   = 1'b1;
            m_post_rst[k] = 1'b1;
            m_rdata[k]    = 32'd0;
            m_rknown[k]   = 1'b1;
            m_cnt[k]      = 32'd0;
        end else begin
            m_rdata[k]  = din ? m_mem[k][didx] : 32'd0;
            m_rknown[k] = din ? m_known[k][didx] : 1'b1;
            if (!hold) begin
                m_tick[k]++;
                m_post_rst[k] = 1'b0;
                if (req) begin
                    e.fault = !fin;
                    e.data  = fin ? m_mem[k][fidx] : 32'd0;
                    e.known = fin ? m_known[k][fidx] : 1'b1;
                    e.due   = m_tick[k] + lat_of(k) - 1;
                    m_q[k].push_back(e);
                    if (fin && m_cnt[k] != 32'hFFFF_FFFF) m_cnt[k]++;
                end
                if (m_q[k].size() > 0 && m_q[k][0].due == m_tick[k]) begin
                    e = m_q[k].pop_front();
                    m_valid[k]  = 1'b1;
                    m_fault[k]  = e.fault;
                    m_data[k]   = e.data;
                    m_dknown[k] = e.known;
                end else begin
                    m_valid[k] = 1'b0;
                end
            end
        end
        if (dbg_we && din) begin
            m_mem[k][didx]   = dbg_wdata;
            m_known[k][didx] = 1'b1;
        end
    endtask

    task automatic compare(input int k);
        check_eq($sformatf("ready%0d", k), 32'(o_ready[k]), 32'(!hold));
        check_eq($sformatf("valid%0d", k), 32'(o_valid[k]), 32'(m_valid[k]));
        if (m_valid[k] || m_post_rst[k]) begin
            check_eq($sformatf("fault%0d", k), 32'(o_fault[k]), 32'(m_fault[k]));
            if (m_dknown[k]) check_eq($sformatf("data%0d", k), o_data[k], m_data[k]);
        end
        if (m_rknown[k]) check_eq($sformatf("rdata%0d", k), o_rdata[k], m_rdata[k]);
        check_eq($sformatf("count%0d", k), o_count[k], m_cnt[k]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) model_step(k);
        for (int k = 0; k < N; k++) compare(k);
    endtask

    task automatic step(input logic r, input logic [29:0] a, input logic h,
                        input logic we, input logic [29:0] da, input logic [31:0] wd);
        req       = r;
        addr      = a;
        hold      = h;
        dbg_we    = we;
        dbg_addr  = da;
        dbg_wdata = wd;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0);
    endtask

    function automatic logic [29:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 30'h0000_0FFF;
            1:       return 30'h0000_1FFF;
            2:       return 30'h0000_2000;
            3:       return 30'h3FFF_FFFF;
            4, 5, 6: return 30'($urandom_range(0, 15));
            default: return 30'(32'h1000 + $urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        rst = 1'b1; req = 1'b0; addr = '0; hold = 1'b0;
        dbg_addr = '0; dbg_we = 1'b0; dbg_wdata = '0;
        tick();
        tick();
        for (int k = 0; k < N; k++) check_eq($sformatf("rst_valid%0d", k), 32'(o_valid[k]), 32'd0);
        rst = 1'b0;

        // Back-to-back fetches of words 0 and 1
        step(1'b0, 30'd0, 1'b0, 1'b1, 30'd0, 32'h0080_4693);
        step(1'b0, 30'd0, 1'b0, 1'b1, 30'd1, 32'h0000_1137);
        step(1'b1, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0);
        check_eq("t1_valid_a", 32'(o_valid[0]), 32'd1);
        check_eq("t1_data_a", o_data[0], 32'h0080_4693);
        step(1'b1, 30'd1, 1'b0, 1'b0, 30'd0, 32'd0);
        check_eq("t1_data_b", o_data[0], 32'h0000_1137);
        check_eq("t1_fault_b", 32'(o_fault[0]), 32'd0);
        check_eq("t1_count", o_count[0], 32'd2);
        idle(4);

        // Hold in the middle of a LATENCY=3 burst
        step(1'b0, 30'd0, 1'b0, 1'b1, 30'h1000, 32'h1111_0000);
        step(1'b0, 30'd0, 1'b0, 1'b1, 30'h1001, 32'h1111_0001);
        step(1'b0, 30'd0, 1'b0, 1'b1, 30'h1002, 32'h1111_0002);
        step(1'b1, 30'h1000, 1'b0, 1'b0, 30'd0, 32'd0);
        step(1'b1, 30'h1001, 1'b0, 1'b0, 30'd0, 32'd0);
        step(1'b1, 30'h1002, 1'b1, 1'b0, 30'd0, 32'd0);
        check_eq("t2_hold_valid", 32'(o_valid[1]), 32'd0);
        step(1'b1, 30'h1002, 1'b1, 1'b0, 30'd0, 32'd0);
        step(1'b1, 30'h1002, 1'b0, 1'b0, 30'd0, 32'd0);
        check_eq("t2_data_a", o_data[1], 32'h1111_0000);
        idle(1);
        check_eq("t2_data_b", o_data[1], 32'h1111_0001);
        idle(1);
        check_eq("t2_data_c", o_data[1], 32'h1111_0002);
        idle(1);
        check_eq("t2_no_dup", 32'(o_valid[1]), 32'd0);
        idle(2);

        // Range boundaries around BASE_ADDR=0x4000
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        step(1'b0, 30'd0, 1'b0, 1'b1, 30'h0FFF, 32'h3FFC_3FFC);
        step(1'b0, 30'd0, 1'b0, 1'b1, 30'h1FFF, 32'h7FFC_7FFC);
        step(1'b1, 30'h0FFF, 1'b0, 1'b0, 30'd0, 32'd0);
        step(1'b1, 30'h1000, 1'b0, 1'b0, 30'd0, 32'd0);
        step(1'b1, 30'h1FFF, 1'b0, 1'b0, 30'd0, 32'd0);
        step(1'b1, 30'h2000, 1'b0, 1'b0, 30'd0, 32'd0);
        idle(1);
        check_eq("t3_fault_in", 32'(o_fault[1]), 32'd0);
        check_eq("t3_data_in", o_data[1], 32'h7FFC_7FFC);
        idle(1);
        check_eq("t3_fault_hi", 32'(o_fault[1]), 32'd1);
        check_eq("t3_data_hi", o_data[1], 32'd0);
        check_eq("t3_count1", o_count[1], 32'd2);
        check_eq("t3_count0", o_count[0], 32'd1);
        idle(3);

        // Debug write and fetch of the same word in one cycle
        step(1'b0, 30'd0, 1'b0, 1'b1, 30'd5, 32'hAAAA_AAAA);
        step(1'b1, 30'd5, 1'b0, 1'b1, 30'd5, 32'h5555_5555);
        check_eq("t4_fetch_old", o_data[0], 32'hAAAA_AAAA);
        check_eq("t4_rdata_old", o_rdata[0], 32'hAAAA_AAAA);
        step(1'b1, 30'd5, 1'b0, 1'b0, 30'd5, 32'd0);
        check_eq("t4_fetch_new", o_data[0], 32'h5555_5555);
        idle(4);

        // Reset with two LATENCY=4 fetches in flight
        step(1'b1, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0);
        step(1'b1, 30'd1, 1'b0, 1'b0, 30'd0, 32'd0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_eq("t5_count", o_count[2], 32'd0);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check_eq($sformatf("t5_squash%0d", i), 32'(o_valid[2]), 32'd0);
        end
        step(1'b1, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0);
        idle(3);
        check_eq("t5_mem_kept", o_data[2], 32'h0080_4693);
        idle(1);

        // Counter saturation
        force g_dut[0].u_dut.r_fetch_count = 32'hFFFF_FFFE;
        #1;
        release g_dut[0].u_dut.r_fetch_count;
        m_cnt[0] = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) step(1'b1, 30'd1, 1'b0, 1'b0, 30'd0, 32'd0);
        check_eq("t6_saturate", o_count[0], 32'hFFFF_FFFF);
        idle(4);

        // Randomised traffic over a pre-loaded address pool
        for (int w = 0; w < 16; w++) begin
            step(1'b0, 30'd0, 1'b0, 1'b1, 30'(w), $urandom);
            step(1'b0, 30'd0, 1'b0, 1'b1, 30'(32'h1000 + w), $urandom);
        end
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            step(($urandom_range(0, 9) < 7), rand_addr(), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 4) == 0), rand_addr(), $urandom);
        end
        rst = 1'b0;
        idle(6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/inst_mem_pipe.md
Name: inst_mem_pipe

Overview:
- Parametrised successor to the single-cycle instruction store: word-addressed instruction memory feeding the CPU IF stage.
- Adds:
  - a configurable base address and depth
  - a configurable read latency (1–4 cycles) with valid tagging
  - a CPU stall (hold) input
  - an out-of-range fault flag
  - a fetch performance counter
- Keeps the independent debug read/write port used by the test harness to load and inspect programs.

Parameters:
- ADDR_WIDTH, 12, word-index bits; depth = 2^ADDR_WIDTH words.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to 4·2^ADDR_WIDTH.
- LATENCY, 1, cycles from an accepted fetch to fetch_valid; legal range 1..4.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_req  in  1  fetch request this cycle.
- fetch_addr  in  30  word address [31:2].
- fetch_hold  in  1  CPU stall; freezes the pipeline and outputs.
- fetch_ready  out  1  equals !fetch_hold; a request is accepted when fetch_req && fetch_ready.
- fetch_valid  out  1  fetch_data/fetch_fault correspond to a request accepted LATENCY cycles earlier (not counting held cycles).
- fetch_data  out  32  instruction word; 0 on fault.
- fetch_fault  out  1  the accepted address was outside [BASE_ADDR, BASE_ADDR + 4·depth).
- debug_addr  in  30  debug word address [31:2].
- debug_wr_en  in  1  debug write strobe.
- debug_wdata  in  32  debug write data.
- debug_rdata  out  32  registered debug read; 0 if out of range.
- fetch_count  out  32  number of accepted in-range fetches; saturates at 32'hFFFF_FFFF.

Behaviour:
- Reset (rst=1 at an edge):
  - fetch_valid=0, fetch_data=0, fetch_fault=0, debug_rdata=0, fetch_count=0.
  - All in-flight pipeline stages are squashed.
  - Memory contents are not reset. Debug writes in the reset cycle are still performed.
- Range check:
  - offset = {fetch_addr,2'b00} − BASE_ADDR, computed in 32 bits.
  - In range iff the offset bits above ADDR_WIDTH+2 are zero.
  - Same rule applies to debug_addr.
- Index: offset[ADDR_WIDTH+1:2].
- Fetch pipeline, stage 1 (memory read register):
  - An accepted request samples mem[idx] (or 0 plus fault=1) and tags the stage valid.
  - A cycle with no accepted request writes valid=0 into stage 1.
- Stages 2..LATENCY are plain shift registers of {valid, fault, data}. The last stage drives the outputs directly.
  - LATENCY=1: outputs appear the cycle after acceptance (same timing as the previous block).
- Hold:
  - While fetch_hold=1, every stage and all outputs keep their values. fetch_req is ignored and fetch_count is unchanged.
  - On release, the pipeline resumes with no loss or duplication.
- fetch_count increments by 1 on each accepted, non-faulting request and stops at all-ones.
- Debug port, independent of hold:
  - debug_rdata <= in-range ? mem[debug_idx] : 0, every cycle.
  - If debug_wr_en and in range, mem[debug_idx] <= debug_wdata. Out-of-range writes are dropped silently.
- Same-address collision (debug write and fetch read of the same index in one cycle):
  - Read-before-write: the fetch returns the old word.
  - debug_rdata also returns the old word.
  - The new word is visible from the next cycle.
- Illegal LATENCY (outside 1..4): elaboration error via a generate-time check.
- Memory has no initial content requirement; the bench loads it through the debug port.

Test Plan:
1. LATENCY=1, BASE_ADDR=0: debug-write 32'h00804693 to word 0 and 32'h00001137 to word 1; fetch word 0, then word 1, on consecutive cycles.
   -> fetch_valid high on cycles +1 and +2, data 00804693 then 00001137, fault=0, fetch_count=2.
2. LATENCY=3: fetch words 0, 1, 2 back-to-back; assert fetch_hold for 2 cycles after the second request.
   -> Outputs frozen during hold. All three words emerge in order, each exactly 3 unheld cycles after acceptance. No duplicate valid.
3. BASE_ADDR=32'h0000_4000, ADDR_WIDTH=12: fetch byte addresses 0x3FFC, 0x4000, 0x7FFC, 0x8000.
   -> Faults 1, 0, 0, 1. Data is 0 for the faulting fetches. fetch_count=2.
4. Collision: word 5 = 32'hAAAA_AAAA; in one cycle, debug-write 32'h5555_5555 to word 5 and fetch word 5.
   -> Fetch returns AAAAAAAA, debug_rdata returns AAAAAAAA. The next fetch of word 5 returns 55555555.
5. Reset mid-flight, LATENCY=4: two fetches in flight, then assert rst for 1 cycle.
   -> fetch_valid stays 0 for the following 4 cycles. fetch_count=0. Memory retains its contents (a fetch after reset returns the loaded word).
6. Counter saturation: force fetch_count to 32'hFFFF_FFFE through the bench hierarchy, then perform 3 in-range fetches.
   -> fetch_count reads FFFFFFFF and holds there.
